// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and glitch counter constants for debounce_filter
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  localparam int                      GLITCH_CNT_W   = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, async active-low reset to 0
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - switch debouncer with registered level/edge/busy outputs
// Optional abort counter output Glitch_Cnt enabled by DEBOUNCE_GLITCH_CNT_EN.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic Raw_In,
  output logic Out_Clean,
  output logic Out_Rise,
  output logic Out_Fall,
  output logic Busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] Glitch_Cnt
`endif
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_q;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (Raw_In),
    .Q   (sync_q)
  );

  // Outputs are updated on the same edge as the state so they stay glitch-free.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= STABLE_LO;
      cnt       <= '0;
      Out_Clean <= 1'b0;
      Out_Rise  <= 1'b0;
      Out_Fall  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Out_Rise <= 1'b0;
      Out_Fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync_q) begin
            state <= PEND_HI;
            cnt   <= CNT_ONE;
            Busy  <= 1'b1;
          end
        end
        PEND_HI: begin
          if (!sync_q) begin
            state <= STABLE_LO;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            state     <= STABLE_HI;
            cnt       <= '0;
            Busy      <= 1'b0;
            Out_Clean <= 1'b1;
            Out_Rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync_q) begin
            state <= PEND_LO;
            cnt   <= CNT_ONE;
            Busy  <= 1'b1;
          end
        end
        PEND_LO: begin
          if (sync_q) begin
            state <= STABLE_HI;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            Busy      <= 1'b0;
            Out_Clean <= 1'b0;
            Out_Fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic abort;

  always_comb begin
    abort = ((state == PEND_HI) && !sync_q) || ((state == PEND_LO) && sync_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Glitch_Cnt <= '0;
    end else if (abort && (Glitch_Cnt != GLITCH_CNT_MAX)) begin
      Glitch_Cnt <= Glitch_Cnt + GLITCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 4, meaning the number of consecutive synchronized samples at a new level required to accept it; legal range 1..255.
REQ-002 SHALL have port CLK  input  1  system clock; all flops sample on the rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port Raw_In  input  1  asynchronous, bouncing input (switch/button).
REQ-005 SHALL have port Out_Clean  output  1  debounced level, which directly feeds the downstream sequence FSM In1.
REQ-006 SHALL have port Out_Rise  output  1  one-cycle pulse when Out_Clean goes 0->1.
REQ-007 SHALL have port Out_Fall  output  1  one-cycle pulse when Out_Clean goes 1->0.
REQ-008 SHALL have port Busy  output  1  high while in a pending state.

Function
REQ-009 SHALL pass Raw_In through a two-flop synchronizer; sync_q denotes the second-flop output.
REQ-010 SHALL implement states STABLE_LO, PEND_HI, STABLE_HI and PEND_LO, each held in a registered state variable.
REQ-011 STABLE_LO: sync_q=1 -> PEND_HI with cnt=1; otherwise SHALL remain in STABLE_LO.
REQ-012 PEND_HI: sync_q=0 -> STABLE_LO with cnt cleared (glitch abort); sync_q=1 with cnt==DEBOUNCE_CNT -> STABLE_HI; else cnt SHALL increment.
REQ-013 STABLE_HI and PEND_LO SHALL mirror REQ-011 and REQ-012 with the levels inverted.
REQ-014 If DEBOUNCE_CNT=1, then PEND_x SHALL still be entered for one cycle before STABLE_x.
REQ-015 Out_Clean SHALL be 1 exactly in STABLE_HI and PEND_LO, and SHALL be registered.
REQ-016 Out_Rise/Out_Fall SHALL be registered and high only in the first cycle Out_Clean shows the new value; they SHALL never both be high.
REQ-017 For Raw_In held steady, Out_Clean SHALL change on the (DEBOUNCE_CNT+3)th rising CLK edge after the Raw_In change (2 sync edges + 1 entry edge + DEBOUNCE_CNT samples).
REQ-018 Any Raw_In pulse shorter than DEBOUNCE_CNT+1 synchronized cycles SHALL leave Out_Clean, Out_Rise and Out_Fall unchanged.
REQ-019 The counter width SHALL hold DEBOUNCE_CNT without wrap; cnt SHALL never exceed DEBOUNCE_CNT.
REQ-020 Busy SHALL be 1 exactly in PEND_HI and PEND_LO.

Reset
REQ-021 RST=0 SHALL asynchronously force both synchronizer flops to 0, the state to STABLE_LO, cnt to 0, and Out_Clean, Out_Rise, Out_Fall and Busy to 0.
REQ-022 Reset asserted mid-pending SHALL abandon the pending level with no pulse output; after release, sampling SHALL restart from the synchronizer.
REQ-023 If Raw_In=1 at reset release, the block SHALL take the normal REQ-017 path and emit Out_Rise.

Configuration
REQ-024 With macro DEBOUNCE_GLITCH_CNT_EN defined, output Glitch_Cnt [7:0] SHALL exist and increment on every PEND->STABLE abort (REQ-012 abort path and its mirror).
REQ-025 Glitch_Cnt SHALL saturate at 255 and be cleared only by reset.
REQ-026 Without DEBOUNCE_GLITCH_CNT_EN, the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package debounce_pkg SHALL hold the state encoding constants (STABLE_LO=0, PEND_HI=1, STABLE_HI=2, PEND_LO=3) and the Glitch_Cnt width/saturation constant.
REQ-028 The synchronizer SHALL be a sub-module sync_2ff (ports CLK, RST, D, Q, async active-low reset to 0).

Verification
REQ-029 Reset with DEBOUNCE_CNT=4 and Raw_In=0, then Raw_In=1 held -> Out_Clean rises on edge 7 after the change; Out_Rise high for exactly that one cycle; Busy high for 4 cycles before it.
REQ-030 From STABLE_HI, Raw_In=0 for 3 cycles then 1 -> Out_Clean stays 1, no Out_Fall pulse, and Glitch_Cnt (if enabled) increments by 1.
REQ-031 Bounce train 1,0,1,0,1 (one cycle each) then steady 1 -> exactly one Out_Rise, occurring DEBOUNCE_CNT+3 edges after the final 0->1 edge.
REQ-032 RST asserted while Busy=1 in PEND_HI -> all outputs 0 immediately (asynchronously); after release with Raw_In=1, Out_Rise follows 7 edges later.
REQ-033 With DEBOUNCE_CNT=1 -> Out_Clean changes 4 edges after Raw_In; with DEBOUNCE_GLITCH_CNT_EN and 300 aborted glitches -> Glitch_Cnt=255.
REQ-034 Output chained into the downstream sequence FSM, Raw_In pattern high, then low, each level longer than the debounce time -> FSM reaches its output-high state exactly once.
